// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - Opcode encodings OP_ADD .. OP_ROR (1101-1111 are illegal and decode to a zero result).
//   - FSM state encoding ST_IDLE / ST_MUL / ST_HOLD.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_INC = 4'b1000;
    localparam logic [3:0] OP_DEC = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_ROL = 4'b1011;
    localparam logic [3:0] OP_ROR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add unsigned multiplier, one partial product per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : latch a/b and begin; takes WIDTH further cycles
//   a, b       : operands (sampled only on start)
//   done       : one-cycle pulse, prod is complete while it is high
//   prod       : full 2*WIDTH-bit product
module alu_seq_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic               done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
            done_q   <= 1'b0;
        end else if (run_q) begin
            // Add the shifted multiplicand for each set multiplier bit, LSB first.
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            run_q    <= (cnt_q != CNT_LAST);
            done_q   <= (cnt_q == CNT_LAST);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign prod = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready-handshaked ALU (10 base ops plus MUL, ROL, ROR).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (A, B, opcode)
//   out_valid/out_ready : result handshake (result, zero, carry, sign)
//   busy                : high while the iterative multiply runs
// Optional: define ALU_SEQ_OVERFLOW_EN to add the 'overflow' output (signed overflow
// for ADD/SUB/INC/DEC, registered alongside result).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             sign,
`ifdef ALU_SEQ_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             busy
);

    state_e             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q, carry_q, sign_q;

    logic               accept, is_mul, load_en, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     add_w, sub_w, inc_w, dec_w;
    logic [WIDTH-1:0]   alu_res, load_res;
    logic               alu_carry, load_carry;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (opcode == OP_MUL);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_mul),
        .a     (A),
        .b     (B),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Extra top bit carries the carry-out / borrow.
    assign add_w = {1'b0, A} + {1'b0, B};
    assign sub_w = {1'b0, A} - {1'b0, B};
    assign inc_w = {1'b0, A} + (WIDTH + 1)'(1);
    assign dec_w = {1'b0, A} - (WIDTH + 1)'(1);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (opcode)
            OP_ADD: {alu_carry, alu_res} = add_w;
            OP_SUB: {alu_carry, alu_res} = sub_w;
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOT: alu_res = ~A;
            OP_SHL: {alu_carry, alu_res} = {A[WIDTH-1], A[WIDTH-2:0], 1'b0};
            OP_SHR: {alu_res, alu_carry} = {1'b0, A[WIDTH-1:1], A[0]};
            OP_INC: {alu_carry, alu_res} = inc_w;
            OP_DEC: {alu_carry, alu_res} = dec_w;
            OP_ROL: {alu_carry, alu_res} = {A[WIDTH-1], A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR: {alu_carry, alu_res} = {A[0], A[0], A[WIDTH-1:1]};
            default: ;  // MUL handled by u_mul; illegal codes give zero
        endcase
    end

    // Output register source: multiplier when finishing a MUL, else the single-cycle path.
    assign load_res   = (state_q == ST_MUL) ? mul_prod[WIDTH-1:0] : alu_res;
    assign load_carry = (state_q == ST_MUL) ? (|mul_prod[2*WIDTH-1:WIDTH]) : alu_carry;
    assign load_en    = (accept && !is_mul) || ((state_q == ST_MUL) && mul_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_q <= is_mul ? ST_MUL : ST_HOLD;
                ST_MUL:  if (mul_done) state_q <= ST_HOLD;
                ST_HOLD: begin
                    // Drain and refill on the same edge: no bubble between results.
                    if (out_ready) begin
                        if (accept) state_q <= is_mul ? ST_MUL : ST_HOLD;
                        else        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (load_en) begin
                result_q <= load_res;
                zero_q   <= (load_res == '0);
                carry_q  <= load_carry;
                sign_q   <= load_res[WIDTH-1];
            end
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign sign   = sign_q;

`ifdef ALU_SEQ_OVERFLOW_EN
    logic alu_ovf, ovf_q;

    // Signed overflow: operands agree in sign (after B inversion for SUB) but result differs.
    always_comb begin
        alu_ovf = 1'b0;
        case (opcode)
            OP_ADD: alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
            OP_SUB: alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
            OP_INC: alu_ovf = !A[WIDTH-1] && inc_w[WIDTH-1];
            OP_DEC: alu_ovf = A[WIDTH-1] && !dec_w[WIDTH-1];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (load_en) begin
            ovf_q <= (state_q == ST_MUL) ? 1'b0 : alu_ovf;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8) with an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;
    localparam int M = 256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   opcode = '0;
    logic         in_ready, out_valid, zero, carry, sign, busy;
    logic [W-1:0] result;
`ifdef ALU_SEQ_OVERFLOW_EN
    logic         overflow;
`endif

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .sign      (sign),
`ifdef ALU_SEQ_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Reference model: returns {ovf, carry, result} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [3:0] op, input int a, input int b);
        int r, s, p, sa, sb;
        bit c, o;
        r = 0; c = 0; o = 0;
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        case (op)
            4'd0:  begin r = (a + b) % M; c = (a + b) >= M; s = sa + sb;
                         o = (s > M / 2 - 1) || (s < -M / 2); end
            4'd1:  begin r = (a - b + M) % M; c = a < b; s = sa - sb;
                         o = (s > M / 2 - 1) || (s < -M / 2); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = (M - 1) - a;
            4'd6:  begin r = (a * 2) % M; c = a >= M / 2; end
            4'd7:  begin r = a / 2; c = (a % 2) == 1; end
            4'd8:  begin r = (a + 1) % M; c = a == M - 1; o = (sa + 1) > M / 2 - 1; end
            4'd9:  begin r = (a - 1 + M) % M; c = a == 0; o = (sa - 1) < -M / 2; end
            4'd10: begin p = a * b; r = p % M; c = p >= M; end
            4'd11: begin r = (a * 2) % M + a / (M / 2); c = a >= M / 2; end
            4'd12: begin r = a / 2 + (a % 2) * (M / 2); c = (a % 2) == 1; end
            default: ;
        endcase
        return {o, c, r[W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE with out_ready=1, wait for the result, then let it drain.
    task automatic run_one(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic c, output logic z,
                           output logic s, output logic o, output bit timeout);
        int n;
        opcode = op; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 30) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        timeout = !out_valid;
        r = result; c = carry; z = zero; s = sign;
`ifdef ALU_SEQ_OVERFLOW_EN
        o = overflow;
`else
        o = 1'b0;
`endif
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b0 || carry !== 1'b0 ||
            sign !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b r=%0d z=%b c=%b s=%b busy=%b want all 0",
                     out_valid, result, zero, carry, sign, busy);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [3:0]   t_op [9]  = '{4'd0, 4'd1, 4'd9, 4'd14, 4'd10, 4'd11, 4'd12, 4'd6, 4'd0};
        int           t_a  [9]  = '{200, 5, 0, 77, 16, 8'h81, 8'h01, 8'hC0, 100};
        int           t_b  [9]  = '{100, 10, 0, 33, 20, 0, 0, 0, 100};
        int           t_r  [9]  = '{44, 251, 255, 0, 64, 8'h03, 8'h80, 8'h80, 200};
        bit           t_c  [9]  = '{1, 1, 1, 0, 1, 1, 1, 1, 0};
        bit           t_o  [9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic [W-1:0] r;
        logic         c, z, s, o;
        bit           to;
        for (int i = 0; i < 9; i++) begin
            run_one(t_op[i], W'(t_a[i]), W'(t_b[i]), r, c, z, s, o, to);
            checks++;
            if (to || r !== W'(t_r[i]) || c !== t_c[i] || z !== (t_r[i] == 0) ||
                s !== (t_r[i] >= M / 2)) begin
                errors++;
                $display("FAIL directed_%0d: got to=%b r=%0d c=%b z=%b s=%b want r=%0d c=%b z=%b s=%b",
                         i, to, r, c, z, s, t_r[i], t_c[i], t_r[i] == 0, t_r[i] >= M / 2);
            end
`ifdef ALU_SEQ_OVERFLOW_EN
            checks++;
            if (o !== t_o[i]) begin
                errors++;
                $display("FAIL directed_ovf_%0d: got %b want %b", i, o, t_o[i]);
            end
`else
            if (t_o[i] && o) $display("note: overflow unused in this build");
`endif
        end
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] a, b, r;
        logic         c, z, s, o;
        logic [W+1:0] e;
        bit           to;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom_range(0, M - 1));
            b  = W'($urandom_range(0, M - 1));
            e  = model(op, int'(a), int'(b));
            run_one(op, a, b, r, c, z, s, o, to);
            checks++;
            if (to || r !== e[W-1:0] || c !== e[W] || z !== (e[W-1:0] == 0) ||
                s !== e[W-1]) begin
                errors++;
                $display("FAIL random op=%0d a=%0d b=%0d: got to=%b r=%0d c=%b z=%b s=%b want r=%0d c=%b",
                         op, a, b, to, r, c, z, s, e[W-1:0], e[W]);
            end
`ifdef ALU_SEQ_OVERFLOW_EN
            checks++;
            if (o !== e[W+1]) begin
                errors++;
                $display("FAIL random_ovf op=%0d a=%0d b=%0d: got %b want %b", op, a, b, o, e[W+1]);
            end
`endif
        end
    endtask

    task automatic test_mul_timing();
        out_ready = 1'b0;
        opcode = 4'd10; A = 8'd16; B = 8'd20; in_valid = 1'b1;
        tick();  // accepted at this edge (T)
        // Input changes while multiplying must be ignored.
        opcode = 4'd0; A = W'($urandom); B = W'($urandom);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy_%0d: got busy=%b in_ready=%b out_valid=%b want 1 0 0",
                         k, busy, in_ready, out_valid);
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_early: got out_valid=%b want 0 at T+8", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || result !== 8'd64 || carry !== 1'b1 || busy !== 1'b0 ||
            zero !== 1'b0 || sign !== 1'b0) begin
            errors++;
            $display("FAIL mul_result: got v=%b r=%0d c=%b busy=%b z=%b s=%b want 1 64 1 0 0 0",
                     out_valid, result, carry, busy, zero, sign);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0]   ops [3] = '{4'd0, 4'd4, 4'd6};
        logic [W-1:0] a [3], b [3];
        logic [W+1:0] e;
        for (int i = 0; i < 3; i++) begin
            a[i] = W'($urandom);
            b[i] = W'($urandom);
        end
        out_ready = 1'b1;
        opcode = ops[0]; A = a[0]; B = b[0]; in_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            e = model(ops[i], int'(a[i]), int'(b[i]));
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== e[W-1:0] ||
                carry !== e[W]) begin
                errors++;
                $display("FAIL b2b_%0d: got v=%b rdy=%b r=%0d c=%b want 1 1 %0d %b",
                         i, out_valid, in_ready, result, carry, e[W-1:0], e[W]);
            end
            if (i < 2) begin
                opcode = ops[i + 1]; A = a[i + 1]; B = b[i + 1];
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] a, b;
        logic [W+1:0] e;
        a = W'($urandom); b = W'($urandom);
        e = model(4'd2, int'(a), int'(b));
        out_ready = 1'b0;
        opcode = 4'd2; A = a; B = b; in_valid = 1'b1;
        tick();
        opcode = 4'd3; A = ~a; B = ~b;  // must not be taken while stalled
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e[W-1:0] ||
                carry !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got v=%b rdy=%b r=%0d c=%b want 1 0 %0d 0",
                         k, out_valid, in_ready, result, carry, e[W-1:0]);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || result !== e[W-1:0]) begin
            errors++;
            $display("FAIL stall_release: got v=%b r=%0d want 0 %0d", out_valid, result, e[W-1:0]);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] r;
        logic         c, z, s, o;
        logic [W+1:0] e;
        bit           to, stale;
        out_ready = 1'b1;
        opcode = 4'd10; A = W'($urandom_range(1, M - 1)); B = W'($urandom_range(1, M - 1));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== '0 || carry !== 1'b0 ||
            zero !== 1'b0 || sign !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_mul_reset: got v=%b busy=%b r=%0d c=%b z=%b s=%b rdy=%b want 0 0 0 0 0 0 1",
                     out_valid, busy, result, carry, zero, sign, in_ready);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL mid_mul_stale: got stale out_valid/busy after reset want none");
        end
        A = W'($urandom); B = W'($urandom);
        e = model(4'd0, int'(A), int'(B));
        run_one(4'd0, A, B, r, c, z, s, o, to);
        checks++;
        if (to || r !== e[W-1:0] || c !== e[W]) begin
            errors++;
            $display("FAIL post_reset_add: got to=%b r=%0d c=%b want r=%0d c=%b",
                     to, r, c, e[W-1:0], e[W]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mul_timing();
        test_back_to_back();
        test_stall();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
